// File: rtl/cnn_cfg_pkg.sv
// Shared configuration helpers and state encoding for the convolution engine
// output sequencer.
package cnn_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // MAC beats needed to finish one output neuron.
    function automatic int beats_per_neuron(input int in_ch, input int lanes, input int kernel);
        return ((in_ch + lanes - 1) / lanes) * kernel * kernel;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_rdy_seq_wrap_cnt.sv
// Mod-N counter with synchronous clear, count enable and a terminal-count flag.
module wrap_cnt
    import cnn_cfg_pkg::*;
#(
    parameter int N = 2,
    parameter int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= last_o ? '0 : cnt_q + W'(1);
    end

endmodule

// File: rtl/conv_rdy_seq.sv
// Output sequencer: counts MAC beats per neuron and hands completed neurons,
// with their linear address and plane, to the output feature-map buffer.
module conv_rdy_seq
    import cnn_cfg_pkg::*;
#(
    parameter int                IN_CH     = 1,
    parameter int                LANES     = 4,
    parameter int                KERNEL    = 5,
    parameter int                ROWS      = 28,
    parameter int                COLS      = 28,
    parameter int                OUT_CH    = 6,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          beat_valid,
    output logic                          beat_ready,
    output logic                          neuron_valid,
    input  logic                          neuron_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [clog2_min1(OUT_CH)-1:0] out_plane,
    output logic                          plane_done,
    output logic                          layer_done,
    output logic                          busy
);

    localparam int BEATS = beats_per_neuron(IN_CH, LANES, KERNEL);
    localparam int PIX   = ROWS * COLS;
    localparam int BC_W  = clog2_min1(BEATS);
    localparam int PX_W  = clog2_min1(PIX);
    localparam int PL_W  = clog2_min1(OUT_CH);

    seq_state_e        state_q, state_d;
    logic              nv_q, nv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PL_W-1:0]   plane_q, plane_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              plane_done_q;
    logic              layer_done_q, layer_done_d;

    logic [BC_W-1:0]   beat_cnt;
    logic [PX_W-1:0]   pix_cnt;
    logic [PL_W-1:0]   plane_cnt;
    logic              beat_last, pix_last, plane_last;
    logic              start_acc, beat_acc, complete, hs;
    logic              unused_cnt;

    assign start_acc = start && (state_q == IDLE);
    // Only the completing beat can stall, and only while the output slot is full.
    assign beat_ready = (state_q == RUN) && !(beat_last && nv_q && !neuron_ready);
    assign beat_acc   = beat_valid && beat_ready;
    assign complete   = beat_acc && beat_last;
    assign hs         = nv_q && neuron_ready;

    wrap_cnt #(.N(BEATS)) u_beat_cnt (
        .clk(clk), .rst(rst), .clr_i(start_acc), .en_i(beat_acc),
        .cnt_o(beat_cnt), .last_o(beat_last)
    );

    wrap_cnt #(.N(PIX)) u_pix_cnt (
        .clk(clk), .rst(rst), .clr_i(start_acc), .en_i(complete),
        .cnt_o(pix_cnt), .last_o(pix_last)
    );

    wrap_cnt #(.N(OUT_CH)) u_plane_cnt (
        .clk(clk), .rst(rst), .clr_i(start_acc), .en_i(complete && pix_last),
        .cnt_o(plane_cnt), .last_o(plane_last)
    );

    assign unused_cnt = ^{beat_cnt, pix_cnt};

    always_comb begin
        state_d      = state_q;
        layer_done_d = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (complete && pix_last && plane_last) state_d = DRAIN;
            DRAIN: begin
                if (hs) begin
                    state_d      = IDLE;
                    layer_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nv_d        = nv_q;
        addr_d      = addr_q;
        plane_d     = plane_q;
        next_addr_d = next_addr_q;
        if (start_acc)
            next_addr_d = ADDR_BASE;
        // A completion wins over a handshake so back-to-back neurons keep valid high.
        if (complete) begin
            nv_d        = 1'b1;
            addr_d      = next_addr_q;
            plane_d     = plane_cnt;
            next_addr_d = next_addr_q + ADDR_W'(1);
        end else if (hs) begin
            nv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            nv_q         <= 1'b0;
            addr_q       <= '0;
            plane_q      <= '0;
            next_addr_q  <= '0;
            plane_done_q <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            nv_q         <= nv_d;
            addr_q       <= addr_d;
            plane_q      <= plane_d;
            next_addr_q  <= next_addr_d;
            plane_done_q <= complete && pix_last;
            layer_done_q <= layer_done_d;
        end
    end

    assign neuron_valid = nv_q;
    assign out_addr     = addr_q;
    assign out_plane    = plane_q;
    assign plane_done   = plane_done_q;
    assign layer_done   = layer_done_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_conv_rdy_seq.sv
// Directed bench for conv_rdy_seq: a BEATS=8 layer with stalls and restarts,
// plus a BEATS=1 instance exercising 9-bit address wrap.
module tb_conv_rdy_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, bv = 1'b0, nr = 1'b0;
    logic       br, nv, pd, ld, busy;
    logic [15:0] addr;
    logic [0:0]  plane;

    logic       st2 = 1'b0, bv2 = 1'b0, nr2 = 1'b0;
    logic       br2, nv2, pd2, ld2, busy2;
    logic [8:0] addr2;
    logic [0:0] plane2;

    int n_pass = 0, n_fail = 0, n_tot = 0;

    always #5 clk = ~clk;

    conv_rdy_seq #(
        .IN_CH(5), .LANES(4), .KERNEL(2), .ROWS(2), .COLS(2), .OUT_CH(2),
        .ADDR_W(16), .ADDR_BASE(16'h0100)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .beat_valid(bv), .beat_ready(br),
        .neuron_valid(nv), .neuron_ready(nr), .out_addr(addr), .out_plane(plane),
        .plane_done(pd), .layer_done(ld), .busy(busy)
    );

    conv_rdy_seq #(
        .IN_CH(1), .LANES(4), .KERNEL(1), .ROWS(1), .COLS(2), .OUT_CH(1),
        .ADDR_W(9), .ADDR_BASE(9'h1FF)
    ) dut2 (
        .clk(clk), .rst(rst), .start(st2), .beat_valid(bv2), .beat_ready(br2),
        .neuron_valid(nv2), .neuron_ready(nr2), .out_addr(addr2), .out_plane(plane2),
        .plane_done(pd2), .layer_done(ld2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held
        repeat (3) tick();
        chk("rst_br", br, 0);     chk("rst_nv", nv, 0);     chk("rst_addr", addr, 0);
        chk("rst_plane", plane, 0); chk("rst_pd", pd, 0);   chk("rst_ld", ld, 0);
        chk("rst_busy", busy, 0); chk("rst_nv2", nv2, 0);   chk("rst_addr2", addr2, 0);

        // Released without start: beat_ready stays low
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_br", br, 0);
        end

        // Start, first neuron with ready output buffer
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", busy, 1); chk("start_br", br, 1);
        bv = 1'b1; nr = 1'b1;
        repeat (8) tick();
        chk("n1_nv", nv, 1); chk("n1_addr", addr, 16'h0100); chk("n1_plane", plane, 0);
        chk("n1_pd", pd, 0);
        bv = 1'b0; tick();
        chk("n1_hs_nv", nv, 0); chk("n1_hold_addr", addr, 16'h0100);

        // Output buffer stalls: second neuron pending, third stalls on its last beat
        nr = 1'b0; bv = 1'b1;
        repeat (8) tick();
        chk("n2_nv", nv, 1); chk("n2_addr", addr, 16'h0101);
        repeat (7) tick();
        chk("stall_br", br, 0); chk("stall_nv", nv, 1); chk("stall_addr", addr, 16'h0101);
        repeat (2) tick();
        chk("stall2_br", br, 0); chk("stall2_addr", addr, 16'h0101);
        nr = 1'b1; #1;
        chk("comb_br", br, 1);
        tick();
        chk("b2b_nv", nv, 1); chk("b2b_addr", addr, 16'h0102); chk("b2b_pd", pd, 0);
        bv = 1'b0; tick();
        chk("n3_hs_nv", nv, 0); chk("n3_hold_addr", addr, 16'h0102);

        // Rest of the layer, with a start pulse mid-layer that must be ignored
        bv = 1'b1; nr = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            start = (c == 20);
            tick();
            if (c % 8 == 0 && c <= 40) begin
                chk("run_nv", nv, 1);
                chk("run_addr", addr, 16'h0103 + (c / 8) - 1);
                chk("run_plane", plane, (c >= 16) ? 1 : 0);
                chk("run_pd", pd, (c == 8 || c == 40) ? 1 : 0);
            end
            if (c == 12) begin
                chk("gap_nv", nv, 0); chk("gap_pd", pd, 0);
            end
            if (c == 40) begin
                chk("drain_br", br, 0); chk("drain_busy", busy, 1); chk("drain_ld", ld, 0);
            end
            if (c == 41) begin
                chk("done_ld", ld, 1); chk("done_busy", busy, 0); chk("done_nv", nv, 0);
                chk("done_addr", addr, 16'h0107); chk("done_plane", plane, 1);
            end
            if (c == 42) chk("done_ld_pulse", ld, 0);
        end
        start = 1'b0; bv = 1'b0;

        // Reset mid-run with a pending neuron
        start = 1'b1; tick(); start = 1'b0;
        bv = 1'b1; nr = 1'b0;
        repeat (8) tick();
        chk("l2_nv", nv, 1); chk("l2_addr", addr, 16'h0100); chk("l2_plane", plane, 0);
        repeat (3) tick();
        rst = 1'b1; #1;
        chk("arst_nv", nv, 0); chk("arst_addr", addr, 0); chk("arst_plane", plane, 0);
        chk("arst_busy", busy, 0); chk("arst_br", br, 0); chk("arst_pd", pd, 0);
        tick();
        rst = 1'b0; bv = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        bv = 1'b1; nr = 1'b1;
        repeat (8) tick();
        chk("rs_nv", nv, 1); chk("rs_addr", addr, 16'h0100); chk("rs_plane", plane, 0);
        bv = 1'b0; tick();

        // BEATS=1, 9-bit address wraps from 0x1FF to 0x000
        st2 = 1'b1; tick(); st2 = 1'b0;
        chk("w_br", br2, 1);
        bv2 = 1'b1; nr2 = 1'b1;
        tick();
        chk("w1_nv", nv2, 1); chk("w1_addr", addr2, 9'h1FF); chk("w1_pd", pd2, 0);
        tick();
        chk("w2_nv", nv2, 1); chk("w2_addr", addr2, 9'h000); chk("w2_pd", pd2, 1);
        chk("w2_br", br2, 0); chk("w2_plane", plane2, 0);
        bv2 = 1'b0; tick();
        chk("w_ld", ld2, 1); chk("w_busy", busy2, 0); chk("w_nv", nv2, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
